// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: default data width, ALU opcodes
// and the command sequencing states.
package alu_pkg;

  localparam int W_DEFAULT = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  // A command is accepted in IDLE, drives the ALU for one cycle in ISSUE,
  // and its result is sampled into the response queue in CAPTURE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/rsp_fifo.sv
// Response queue: circular buffer of DEPTH entries with a combinational
// head. Also exposes the occupancy it will have after this clock edge so
// the driver can decide whether to offer another command.
module rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = W_DEFAULT + 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count_next
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  // Pointer, storage and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the head never shows unknowns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid      = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count_next = count_d;

  // The driver only accepts commands while there is room, so a push into a full queue is a design bug.
  push_not_full: assert property (@(posedge clk) disable iff (rst) push |-> (count_q < FULL_COUNT));

endmodule

// File: rtl/alu_driver.sv
// ALU driver: accepts one command at a time, registers the operands toward
// an external combinational ALU, captures its result two cycles later and
// queues {zero, carry, result} for a downstream consumer.
module alu_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_chain,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W+1:0] rsp_data,
  output logic [7:0]   op_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  state_e       state_q, state_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [W-1:0] last_result_q, last_result_d;
  logic [7:0]   op_count_q, op_count_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         push;
  logic [CW-1:0] fifo_count_next;

  // Sequencing: accept in IDLE, hold operands through ISSUE, capture the ALU output in CAPTURE.
  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    last_result_d = last_result_q;
    op_count_d    = op_count_q;
    push          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          alu_a_d  = cmd_chain ? last_result_q : cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        push          = 1'b1;
        last_result_d = alu_result;
        op_count_d    = op_count_q + 8'd1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE) && (fifo_count_next < FULL_COUNT);
  end

  // Registered state; ready is a flop so it stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      last_result_q <= '0;
      op_count_q    <= '0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      last_result_q <= last_result_d;
      op_count_q    <= op_count_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W + 2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  ({alu_zero, alu_carry, alu_result}),
    .pop        (rsp_ready),
    .valid      (rsp_valid),
    .head_data  (rsp_data),
    .count_next (fifo_count_next)
  );

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// Testbench for alu_driver: provides a behavioural ALU, a queue-based
// reference model of expected responses, directed scenarios and a
// randomized run long enough to wrap the operation counter.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   cmd_op;
  logic         cmd_chain;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W+1:0] rsp_data;
  logic [7:0]   op_count;

  int compareCount = 0;
  int failCount    = 0;

  logic [W+1:0] expQ[$];
  logic [W-1:0] modelLast;
  int           modelOps;
  bit           randPop;

  alu_driver #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_chain  (cmd_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .op_count   (op_count)
  );

  // Behavioural ALU returning {zero, carry, result}; SUB carry is the borrow.
  function automatic logic [W+1:0] aluModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
    logic [W:0]   wide;
    logic [W-1:0] r;
    logic         c;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    case (op)
      OP_ADD:  begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      OP_SUB:  begin wide = {1'b0, a} - {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_SHL:  begin r = a << 1; c = a[W-1]; end
      default: begin r = a >> 1; c = a[0]; end
    endcase
    return {(r == '0), c, r};
  endfunction

  // The external ALU the driver talks to.
  always_comb {alu_zero, alu_carry, alu_result} = aluModel(alu_a, alu_b, alu_op);

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hang guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted command yields one response in acceptance order.
  task automatic modelIssue(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op, input logic chain);
    logic [W-1:0] effA;
    logic [W+1:0] r;
    effA = chain ? modelLast : a;
    r    = aluModel(effA, b, op);
    expQ.push_back(r);
    modelLast = r[W-1:0];
    modelOps++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randPop) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic chain);
    bit ok;
    ok        = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_chain = chain;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        checkOutput("op_count_at_accept", 32'(op_count), 32'(modelOps % 256));
        modelIssue(a, b, op, chain);
        ok = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    if (!ok) checkOutput("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    randPop   = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && expQ.size() > 0; i++) begin
      tick();
    end
    rsp_ready = 1'b0;
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  // Response monitor: a handshake seen mid-cycle completes at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) checkOutput("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
        else checkOutput("rsp_data", 32'(rsp_data), 32'(expQ.pop_front()));
      end
    end
  end

  // Directed scenarios followed by a randomized run of 256 operations.
  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_chain = 1'b0;
    rsp_ready = 1'b0;
    randPop   = 1'b0;
    modelLast = '0;
    modelOps  = 0;
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_op_count", 32'(op_count), 32'd0);
    #9 rst = 1'b0;
    #1 checkOutput("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_first_edge", 32'(cmd_ready), 32'd1);

    // ADD 9+8 with latency check
    applyStimulus(4'd9, 4'd8, OP_ADD, 1'b0);
    @(negedge clk);
    checkOutput("issue_alu_a", 32'(alu_a), 32'd9);
    checkOutput("issue_alu_b", 32'(alu_b), 32'd8);
    checkOutput("issue_alu_op", 32'(alu_op), 32'(OP_ADD));
    checkOutput("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("capture_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("n3_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("add98_rsp_data", 32'(rsp_data), 32'h11);
    checkOutput("add98_op_count", 32'(op_count), 32'd1);
    tick();
    drain();

    // ADD 3+4 then chained SUB 7
    applyStimulus(4'd3, 4'd4, OP_ADD, 1'b0);
    drain();
    applyStimulus(4'd0, 4'd7, OP_SUB, 1'b1);
    @(negedge clk);
    checkOutput("chain_alu_a", 32'(alu_a), 32'd7);
    checkOutput("chain_alu_op", 32'(alu_op), 32'(OP_SUB));
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("chain_rsp_data", 32'(rsp_data), 32'h20);
    tick();
    drain();

    // Fill the queue, hold a fifth command, release it with one pop
    applyStimulus(4'd1, 4'd2, OP_ADD, 1'b0);
    applyStimulus(4'd15, 4'd3, OP_AND, 1'b0);
    applyStimulus(4'd9, 4'd9, OP_XNOR, 1'b0);
    applyStimulus(4'd12, 4'd0, OP_SHL, 1'b0);
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("full_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    cmd_a     = 4'd2;
    cmd_b     = 4'd5;
    cmd_op    = OP_OR;
    cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("held_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    checkOutput("held_op_count", 32'(op_count), 32'(modelOps % 256));
    rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_pop", 32'(cmd_ready), 32'd1);
    if (cmd_ready) modelIssue(4'd2, 4'd5, OP_OR, 1'b0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("fifth_alu_a", 32'(alu_a), 32'd2);
    checkOutput("fifth_alu_op", 32'(alu_op), 32'(OP_OR));
    tick();
    drain();

    // Pop on the same edge as a capture with two entries queued
    applyStimulus(4'd1, 4'd1, OP_ADD, 1'b0);
    applyStimulus(4'd6, 4'd3, OP_SUB, 1'b0);
    applyStimulus(4'd5, 4'd12, OP_XOR, 1'b0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("collide_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("collide_empty_valid", 32'(rsp_valid), 32'd0);
    checkOutput("collide_queue_left", 32'(expQ.size()), 32'd0);
    tick();

    // Reset while a command is in ISSUE
    applyStimulus(4'd5, 4'd6, OP_ADD, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("midrst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("midrst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("midrst_op_count", 32'(op_count), 32'd0);
    expQ.delete();
    modelLast = '0;
    modelOps  = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      tick();
    end
    checkOutput("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("postrst_op_count", 32'(op_count), 32'd0);
    checkOutput("postrst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomized run of 256 operations with random back-pressure
    randPop = 1'b1;
    for (int n = 0; n < 256; n++) begin
      applyStimulus(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
    end
    drain();
    tick();
    checkOutput("wrap_op_count", 32'(op_count), 32'd0);
    checkOutput("final_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
